// File: rtl/xpu_vpu_pc_tn_vlsu_pkg.sv
// Shared sizing and payload types for the VLSU index/vmask queue (ICQ).
package xpu_vpu_pc_tn_vlsu_pkg;

    localparam int ICQ_ENTRY_NUM           = 8;
    localparam int ICQ_PTR_W               = $clog2(ICQ_ENTRY_NUM) + 1;
    localparam int XPU_VPU_PC_TN_IDX_WIDTH = 64;

    typedef struct packed {
        logic [XPU_VPU_PC_TN_IDX_WIDTH-1:0] idx_offset;
        logic                               vmask;
    } icq_payload_t;

endpackage

// File: rtl/xpu_vpu_pc_tn_vlsu_index_vm_entry.sv
// One ICQ slot: a valid bit set on create and cleared on release or flush,
// plus an unreset payload captured on create.
module xpu_vpu_pc_tn_vlsu_index_vm_entry
    import xpu_vpu_pc_tn_vlsu_pkg::*;
(
    input  logic         clk,
    input  logic         cpurst_b,
    input  logic         flush,
    input  logic         crt_vld,
    input  logic         rls_vld,
    input  icq_payload_t crt_data,
    output logic         entry_vld,
    output icq_payload_t entry_data
);

    logic         r_vld;
    icq_payload_t r_data;
    logic         w_clk_en;

    // Enable of the slot's clock-gate cell: the slot only toggles on its own events.
    assign w_clk_en = crt_vld | rls_vld | flush;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_vld <= 1'b0;
        end else if (w_clk_en) begin
            if (flush) begin
                r_vld <= 1'b0;
            end else if (crt_vld) begin
                r_vld <= 1'b1;
            end else begin
                r_vld <= 1'b0;
            end
        end
    end

    // NOTE: payload storage is deliberately not reset; the valid bit alone
    // qualifies it, and leaving it unreset keeps the reset tree off the datapath.
    always_ff @(posedge clk) begin
        if (crt_vld) begin
            r_data <= crt_data;
        end
    end

    assign entry_vld  = r_vld;
    assign entry_data = r_data;

endmodule

// File: rtl/xpu_vpu_pc_tn_vlsu_index_vm_ctrl.sv
// In-order allocate/release controller for the VLSU index/vmask queue:
// tail pointer allocates on push, head pointer releases on pop, flush empties it.
module xpu_vpu_pc_tn_vlsu_index_vm_ctrl
    import xpu_vpu_pc_tn_vlsu_pkg::*;
#(
    parameter int ENTRY_NUM = ICQ_ENTRY_NUM,
    parameter int PTR_W     = $clog2(ENTRY_NUM) + 1
) (
    input  logic                               vv_icq_ctrl_clk,
    input  logic                               cpurst_b,
    input  logic                               giu_xx_async_flush,
    input  logic                               icq_push_vld,
    output logic                               icq_push_rdy,
    input  logic [XPU_VPU_PC_TN_IDX_WIDTH-1:0] icq_push_idx_offset,
    input  logic                               icq_push_vmask,
    output logic                               icq_pop_vld,
    input  logic                               icq_pop_rdy,
    output logic [XPU_VPU_PC_TN_IDX_WIDTH-1:0] icq_pop_idx_offset,
    output logic                               icq_pop_vmask,
    output logic [PTR_W-1:0]                   icq_entry_cnt,
    output logic                               icq_empty
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]     r_head_ptr;
    logic [PTR_W-1:0]     r_tail_ptr;
    logic [IDX_W-1:0]     w_head_idx;
    logic [IDX_W-1:0]     w_tail_idx;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [ENTRY_NUM-1:0] w_crt_vld;
    logic [ENTRY_NUM-1:0] w_rls_vld;
    logic [ENTRY_NUM-1:0] w_head_dec;
    logic [ENTRY_NUM-1:0] w_entry_vld;
    icq_payload_t         w_entry_data [ENTRY_NUM];
    icq_payload_t         w_push_data;
    icq_payload_t         w_pop_data;

    assign w_head_idx = r_head_ptr[IDX_W-1:0];
    assign w_tail_idx = r_tail_ptr[IDX_W-1:0];

    assign w_full = (w_head_idx == w_tail_idx) && (r_head_ptr[PTR_W-1] != r_tail_ptr[PTR_W-1]);

    // Ready depends only on state: a same-cycle pop never opens a slot for the push.
    assign icq_push_rdy  = ~w_full;
    assign icq_entry_cnt = r_tail_ptr - r_head_ptr;
    assign icq_empty     = (r_head_ptr == r_tail_ptr);

    assign w_push = icq_push_vld & icq_push_rdy & ~giu_xx_async_flush;
    assign w_pop  = icq_pop_vld & icq_pop_rdy & ~giu_xx_async_flush;

    assign w_push_data.idx_offset = icq_push_idx_offset;
    assign w_push_data.vmask      = icq_push_vmask;

    always_ff @(posedge vv_icq_ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
        end else if (giu_xx_async_flush) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
        end else begin
            if (w_push) begin
                r_tail_ptr <= r_tail_ptr + 1'b1;
            end
            if (w_pop) begin
                r_head_ptr <= r_head_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_crt_vld  = '0;
        w_rls_vld  = '0;
        w_head_dec = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            w_head_dec[i] = (w_head_idx == IDX_W'(i));
            w_crt_vld[i]  = w_push && (w_tail_idx == IDX_W'(i));
            w_rls_vld[i]  = w_pop && w_head_dec[i];
        end
    end

    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_entry
        xpu_vpu_pc_tn_vlsu_index_vm_entry u_entry (
            .clk        (vv_icq_ctrl_clk),
            .cpurst_b   (cpurst_b),
            .flush      (giu_xx_async_flush),
            .crt_vld    (w_crt_vld[g]),
            .rls_vld    (w_rls_vld[g]),
            .crt_data   (w_push_data),
            .entry_vld  (w_entry_vld[g]),
            .entry_data (w_entry_data[g])
        );
    end

    // One-hot AND-OR select of the head slot; no push bypass.
    always_comb begin
        w_pop_data  = '0;
        icq_pop_vld = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            w_pop_data  = w_pop_data | ({$bits(icq_payload_t){w_head_dec[i]}} & w_entry_data[i]);
            icq_pop_vld = icq_pop_vld | (w_head_dec[i] & w_entry_vld[i]);
        end
    end

    assign icq_pop_idx_offset = w_pop_data.idx_offset;
    assign icq_pop_vmask      = w_pop_data.vmask;

    a_vld_matches_cnt : assert property (
        @(posedge vv_icq_ctrl_clk) disable iff (!cpurst_b)
        !giu_xx_async_flush |-> ($countones(w_entry_vld) == int'(icq_entry_cnt))
    );

endmodule
